fwd_scoreboard: RTL and testbench

Parametrised forwarding and hazard unit for the pipelined MIPS core. It tracks in-flight register writers in a shift-register scoreboard and supports producers with different result latencies (ALU, load, multi-cycle). It resolves forwarding for any number of source operands at ID and registers the select into EX. It raises a stall when the youngest matching producer's result will not be forwardable in time. It sits beside the ID/EX pipeline register and drives the EX operand muxes and the IF/ID hold/bubble logic.

---
 rtl/fwd_scoreboard_pkg.sv | 38 +++
 rtl/fwd_scoreboard_match.sv | 52 +++++
 rtl/fwd_scoreboard.sv | 99 +++++++++
 tb/tb_fwd_scoreboard.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_scoreboard_pkg.sv
// ============================================================================
// fwd_pkg : shared types, constants and helpers for the forwarding scoreboard
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package fwd_pkg;

  // Select value meaning "read the register file"
  localparam int FWD_RF = 0;

  // Tracker fields are sized for the widest configuration; narrower ports zero-extend.
  localparam int FWD_AW_MAX = 8;
  localparam int FWD_LW_MAX = 8;

  typedef struct packed {
    logic                  valid;
    logic [FWD_AW_MAX-1:0] dst;
    logic [FWD_LW_MAX-1:0] lat;
  } fwd_entry_t;

  function automatic logic [FWD_LW_MAX-1:0] fwd_clamp(
    input logic [FWD_LW_MAX-1:0] lat,
    input int unsigned           depth
  );
    logic [FWD_LW_MAX-1:0] lim;
    lim = FWD_LW_MAX'(depth);
    if (lat == '0) begin
      return FWD_LW_MAX'(1);
    end else if (lat > lim) begin
      return lim;
    end
    return lat;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_scoreboard_match.sv
// ============================================================================
// fwd_match : youngest-match search of one source operand over the tracker
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_match
  import fwd_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  fwd_entry_t [DEPTH-1:0] entries,
  input  logic [FWD_AW_MAX-1:0]  src,
  input  logic                   used,
  output logic                   hazard,
  output logic [SEL_W-1:0]       sel
);

  logic                  hit;
  int                    hit_j;
  logic [FWD_LW_MAX-1:0] hit_lat;

  always_comb begin
    hit     = 1'b0;
    hit_j   = 0;
    hit_lat = '0;
    // Walk oldest to youngest so the youngest match overrides older ones
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && (entries[k].dst == src)) begin
        hit     = 1'b1;
        hit_j   = k + 1;
        hit_lat = entries[k].lat;
      end
    end
  end

  always_comb begin
    hazard = 1'b0;
    sel    = SEL_W'(FWD_RF);
    if (used && hit) begin
      if (hit_j >= int'(hit_lat)) begin
        sel = SEL_W'(hit_j);
      end else begin
        hazard = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/fwd_scoreboard.sv
// ============================================================================
// fwd_scoreboard : in-flight writer tracker, forwarding select and load-use stall
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3,
  parameter int LAT_W   = 2,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]         id_src_used,
  input  logic                       id_reg_write,
  input  logic [REG_AW-1:0]          id_dst,
  input  logic [LAT_W-1:0]           id_lat,
  input  logic                       flush,
  output logic                       stall,
  output logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel,
  output logic [15:0]                stall_cnt
);

  fwd_entry_t [DEPTH-1:0]     entries_q, entries_d;
  logic [NUM_SRC*SEL_W-1:0]   ex_fwd_sel_q, ex_fwd_sel_d;
  logic [15:0]                stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]         hazard;
  logic [NUM_SRC*SEL_W-1:0]   sel_w;
  logic                       issue;

  generate
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
      logic [FWD_AW_MAX-1:0] src_ext;
      logic                  src_live;

      assign src_ext  = FWD_AW_MAX'(id_src[i*REG_AW +: REG_AW]);
      assign src_live = id_src_used[i] && (src_ext != '0);

      fwd_match #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
      ) u_match (
        .entries (entries_q),
        .src     (src_ext),
        .used    (src_live),
        .hazard  (hazard[i]),
        .sel     (sel_w[i*SEL_W +: SEL_W])
      );
    end
  endgenerate

  assign stall = id_valid && !flush && (|hazard);
  assign issue = id_valid && !stall && !flush;

  always_comb begin
    entries_d = '0;
    for (int k = 1; k < DEPTH; k++) begin
      entries_d[k] = entries_q[k-1];
    end
    // Entry 0 takes the issuing instruction, or a bubble
    if (issue) begin
      entries_d[0].valid = id_reg_write && (id_dst != '0);
      entries_d[0].dst   = FWD_AW_MAX'(id_dst);
      entries_d[0].lat   = fwd_clamp(FWD_LW_MAX'(id_lat), DEPTH);
    end

    ex_fwd_sel_d = issue ? sel_w : '0;

    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      entries_q    <= '0;
      ex_fwd_sel_q <= '0;
      stall_cnt_q  <= '0;
    end else begin
      entries_q    <= entries_d;
      ex_fwd_sel_q <= ex_fwd_sel_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign ex_fwd_sel = ex_fwd_sel_q;
  assign stall_cnt  = stall_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
// tb_fwd_scoreboard : directed self-checking bench for fwd_scoreboard
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_fwd_scoreboard;

  logic        clk = 1'b0;
  logic        rstn;
  logic        id_valid;
  logic [9:0]  id_src;
  logic [1:0]  id_src_used;
  logic        id_reg_write;
  logic [4:0]  id_dst;
  logic [1:0]  id_lat;
  logic        flush;
  logic        stall;
  logic [3:0]  ex_fwd_sel;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  fwd_scoreboard dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_valid     (id_valid),
    .id_src       (id_src),
    .id_src_used  (id_src_used),
    .id_reg_write (id_reg_write),
    .id_dst       (id_dst),
    .id_lat       (id_lat),
    .flush        (flush),
    .stall        (stall),
    .ex_fwd_sel   (ex_fwd_sel),
    .stall_cnt    (stall_cnt)
  );

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [1:0] used, input logic wr, input logic [4:0] dst,
                       input logic [1:0] lat, input logic fl);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_reg_write = wr;
    id_dst       = dst;
    id_lat       = lat;
    flush        = fl;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    repeat (2) step();
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (ex_fwd_sel !== 4'h0) begin n_fail++; $display("FAIL reset_sel: got %h want 0", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", stall_cnt); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_alu_alu();
    drive(1'b1, 5'd1, 5'd2, 2'b11, 1'b1, 5'd3, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_prod_stall: got %b want 0", stall); end
    step();
    drive(1'b1, 5'd3, 5'd3, 2'b11, 1'b1, 5'd5, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu_cons_stall: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0101) begin n_fail++; $display("FAIL alu_sel: got %b want 0101", ex_fwd_sel); end
    idle();
  endtask

  task automatic test_load_use();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 2'b11, 1'b1, 5'd5, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_end: got %b want 0", stall); end
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble_sel: got %b want 0000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL lu_sel: got %b want 0010", ex_fwd_sel); end
    idle();
  endtask

  task automatic test_youngest();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd1, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd4, 5'd3, 2'b11, 1'b1, 5'd6, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL yw_stall: got %b want 1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL yw_stall_end: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b1000) begin n_fail++; $display("FAIL yw_sel: got %b want 1000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL yw_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_zero_unused();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd0, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b11, 1'b1, 5'd8, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero_stall: got %b want 0", stall); end
    step();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd7, 2'd2, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL zero_sel: got %b want 0000", ex_fwd_sel); end
    step();
    drive(1'b1, 5'd7, 5'd1, 2'b10, 1'b1, 5'd9, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL unused_stall: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL unused_sel: got %b want 0000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL zero_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_clamp_multicycle();
    // lat 0 behaves like an ALU producer
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd10, 2'd0, 1'b0);
    step();
    drive(1'b1, 5'd10, 5'd0, 2'b01, 1'b1, 5'd11, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL clamp_stall: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0001) begin n_fail++; $display("FAIL clamp_sel: got %b want 0001", ex_fwd_sel); end
    idle();
    // lat 3 producer, dependent next cycle: two stall cycles
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd9, 2'd3, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd0, 2'b01, 1'b1, 5'd12, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mc_stall1: got %b want 1", stall); end
    step();
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL mc_stall2: got %b want 1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd2;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL mc_stall_end: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0011) begin n_fail++; $display("FAIL mc_sel: got %b want 0011", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL mc_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    idle();
  endtask

  task automatic test_flush();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd5, 2'd1, 1'b1);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b want 0", stall); end
    step();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd5, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL flush_sel: got %b want 0000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL flush_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_next_stall: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0010) begin n_fail++; $display("FAIL flush_next_sel: got %b want 0010", ex_fwd_sel); end
    idle();
  endtask

  task automatic test_reset_mid_stall();
    drive(1'b1, 5'd0, 5'd0, 2'b00, 1'b1, 5'd3, 2'd2, 1'b0);
    step();
    drive(1'b1, 5'd3, 5'd0, 2'b01, 1'b1, 5'd5, 2'd1, 1'b0);
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rms_stall: got %b want 1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    #1 rstn = 1'b0;
    #1;
    exp_cnt = 16'd0;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_stall_rst: got %b want 0", stall); end
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rms_sel_rst: got %b want 0000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rms_cnt_rst: got %0d want 0", stall_cnt); end
    step();
    rstn = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rms_after_stall: got %b want 0", stall); end
    step();
    drive(1'b0, 5'd0, 5'd0, 2'b00, 1'b0, 5'd0, 2'd1, 1'b0);
    n_checks++; if (ex_fwd_sel !== 4'b0000) begin n_fail++; $display("FAIL rms_after_sel: got %b want 0000", ex_fwd_sel); end
    n_checks++; if (stall_cnt !== exp_cnt) begin n_fail++; $display("FAIL rms_after_cnt: got %0d want %0d", stall_cnt, exp_cnt); end
  endtask

  initial begin
    test_reset();
    test_alu_alu();
    test_load_use();
    test_youngest();
    test_zero_unused();
    test_clamp_multicycle();
    test_flush();
    test_reset_mid_stall();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
